// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared constants and helpers for the RF write-port arbiter
package rf_arb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 32;
    localparam int NUM_REQ_DEF    = 4;

    // Smallest r with 2**r >= v, never below 1 so single-entry buses stay legal.
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr_i
module rr_pick #(
    parameter int n_g     = 4,
    parameter int ptr_w_g = 2
) (
    input  logic [n_g-1:0]     req_i,
    input  logic [ptr_w_g-1:0] ptr_i,
    output logic [n_g-1:0]     grant_o,
    output logic [ptr_w_g-1:0] idx_o
);

    localparam logic [ptr_w_g:0] N_W = (ptr_w_g + 1)'(n_g);

    always_comb begin
        logic [ptr_w_g:0] pos;
        logic             found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < n_g; k++) begin
            // ptr_i < n_g always holds, so one conditional subtract performs the wrap
            pos = {1'b0, ptr_i} + (ptr_w_g + 1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            if (!found && req_i[pos[ptr_w_g-1:0]]) begin
                grant_o[pos[ptr_w_g-1:0]] = 1'b1;
                idx_o                     = pos[ptr_w_g-1:0];
                found                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - round-robin arbiter for the RF write port; RF_WR_ARBITER_PRIO0_EN gives requester 0 strict priority
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int data_width_g = DATA_WIDTH_DEF,
    parameter int depth_g      = DEPTH_DEF,
    parameter int num_req_g    = NUM_REQ_DEF
) (
    input  logic                                       clk,
    input  logic                                       rstx,
    input  logic                                       glock_in,
    input  logic [num_req_g-1:0]                       req_valid_in,
    output logic [num_req_g-1:0]                       req_ready_out,
    input  logic [num_req_g*clogb2(depth_g)-1:0]       req_addr_in,
    input  logic [num_req_g*data_width_g-1:0]          req_data_in,
    output logic                                       wload_out,
    output logic [clogb2(depth_g)-1:0]                 wop_out,
    output logic [data_width_g-1:0]                    wdata_out,
    output logic                                       busy_out
);

    localparam int addr_w = clogb2(depth_g);
    localparam int ptr_w  = clogb2(num_req_g);
    localparam logic [ptr_w-1:0] PTR_LAST = ptr_w'(num_req_g - 1);

    logic [num_req_g-1:0]    pick_mask;
    logic [num_req_g-1:0]    pick_grant;
    logic [ptr_w-1:0]        pick_idx;
    logic [num_req_g-1:0]    grant;
    logic [ptr_w-1:0]        gnt_idx;
    logic                    prio0_hit;
    logic                    accept;
    logic [ptr_w-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    wload_q, wload_d;
    logic [addr_w-1:0]       wop_q, wop_d;
    logic [data_width_g-1:0] wdata_q, wdata_d;
    logic [addr_w-1:0]       addr_sel;
    logic [data_width_g-1:0] data_sel;

`ifdef RF_WR_ARBITER_PRIO0_EN
    // Requester 0 bypasses the rotation, so the pointer only ever cycles over 1..n-1.
    localparam logic [ptr_w-1:0] PTR_RST = (num_req_g > 1) ? ptr_w'(1) : ptr_w'(0);
    assign pick_mask = req_valid_in & ~num_req_g'(1);
    assign prio0_hit = req_valid_in[0];
    assign grant     = prio0_hit ? num_req_g'(1) : pick_grant;
    assign gnt_idx   = prio0_hit ? ptr_w'(0) : pick_idx;
`else
    localparam logic [ptr_w-1:0] PTR_RST = ptr_w'(0);
    assign pick_mask = req_valid_in;
    assign prio0_hit = 1'b0;
    assign grant     = pick_grant;
    assign gnt_idx   = pick_idx;
`endif

    rr_pick #(
        .n_g     (num_req_g),
        .ptr_w_g (ptr_w)
    ) u_pick (
        .req_i   (pick_mask),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    assign req_ready_out = (rstx && !glock_in) ? grant : '0;
    assign accept        = |req_ready_out;
    assign busy_out      = (|req_valid_in) & ~accept;

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int k = 0; k < num_req_g; k++) begin
            if (grant[k]) begin
                addr_sel = req_addr_in[slice_lo(k, addr_w) +: addr_w];
                data_sel = req_data_in[slice_lo(k, data_width_g) +: data_width_g];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wload_d  = wload_q;
        wop_d    = wop_q;
        wdata_d  = wdata_q;
        if (accept && !prio0_hit) begin
            rr_ptr_d = (gnt_idx == PTR_LAST) ? PTR_RST : gnt_idx + ptr_w'(1);
        end
        // While locked the stage holds, so a staged write commits at the first unlocked edge.
        if (!glock_in) begin
            wload_d = accept;
            if (accept) begin
                wop_d   = addr_sel;
                wdata_d = data_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            rr_ptr_q <= PTR_RST;
            wload_q  <= 1'b0;
            wop_q    <= '0;
            wdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wload_q  <= wload_d;
            wop_q    <= wop_d;
            wdata_q  <= wdata_d;
        end
    end

    assign wload_out = wload_q;
    assign wop_out   = wop_q;
    assign wdata_out = wdata_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - randomized self-checking bench for rf_wr_arbiter against a behavioural model
module tb_rf_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rstx;
    logic            glock;
    logic [N-1:0]    valid;
    logic [N-1:0]    ready;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic            wload;
    logic [AW-1:0]   wop;
    logic [DW-1:0]   wdata;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    int            m_ptr;
    logic          m_wload;
    logic [AW-1:0] m_wop;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rf [32];
    logic [DW-1:0] dut_rf [32] = '{default: '0};
    int            wr5_cnt = 0;

    rf_wr_arbiter #(.data_width_g(DW), .depth_g(32), .num_req_g(N)) dut (
        .clk           (clk),
        .rstx          (rstx),
        .glock_in      (glock),
        .req_valid_in  (valid),
        .req_ready_out (ready),
        .req_addr_in   (addr),
        .req_data_in   (data),
        .wload_out     (wload),
        .wop_out       (wop),
        .wdata_out     (wdata),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT's write port.
    always @(posedge clk) begin
        if (rstx && !glock && wload) begin
            dut_rf[wop] <= wdata;
            if (wop == 5'd5) wr5_cnt <= wr5_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
`ifdef RF_WR_ARBITER_PRIO0_EN
        m_ptr = 1;
`else
        m_ptr = 0;
`endif
        m_wload = 1'b0;
        m_wop   = '0;
        m_wdata = '0;
    endtask

    function automatic int model_pick();
        int j;
        if (!rstx || glock) return -1;
`ifdef RF_WR_ARBITER_PRIO0_EN
        if (valid[0]) return 0;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (j != 0 && valid[j]) return j;
        end
`else
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (valid[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW] = a;
        data[i*DW +: DW] = d;
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle(output int g);
        logic [N-1:0] exp_ready;
        #1;
        g = model_pick();
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        check("ready", 64'(ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'((|valid) && g < 0));
        @(posedge clk);
        if (!rstx) begin
            model_reset();
        end else if (!glock) begin
            if (m_wload) m_rf[m_wop] = m_wdata;
            if (g >= 0) begin
                m_wload = 1'b1;
                m_wop   = addr[g*AW +: AW];
                m_wdata = data[g*DW +: DW];
`ifdef RF_WR_ARBITER_PRIO0_EN
                if (g != 0) m_ptr = (g == N - 1) ? 1 : g + 1;
`else
                m_ptr = (g + 1) % N;
`endif
            end else begin
                m_wload = 1'b0;
            end
        end
        #1;
        check("wload", 64'(wload), 64'(m_wload));
        check("wop", 64'(wop), 64'(m_wop));
        check("wdata", 64'(wdata), 64'(m_wdata));
        @(negedge clk);
    endtask

    initial begin
        int g;
        int last_g;
        int base5;
        int fair_exp [5] = '{0, 1, 2, 3, 0};

        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        rstx  = 1'b0;
        glock = 1'b0;
        valid = 4'hF;
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'($urandom));
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_wload", 64'(wload), 64'(0));
        check("rst_wop", 64'(wop), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        @(negedge clk);
        rstx = 1'b1;

        // Fairness: all four held valid with addresses 1..4.
        for (int i = 0; i < 5; i++) begin
            cycle(g);
`ifndef RF_WR_ARBITER_PRIO0_EN
            check("fair_gnt", 64'(g), 64'(fair_exp[i]));
            check("fair_wop", 64'(wop), 64'(fair_exp[i] + 1));
`else
            check("prio_gnt", 64'(g), 64'(0));
`endif
        end

        // Lock: grant req2 then hold the staged write through a 3-cycle stall.
        valid = 4'b0100;
        set_req(2, 5'd5, 32'hDEADBEEF);
        base5 = wr5_cnt;
        cycle(g);
        check("lock_gnt", 64'(g), 64'(2));
        valid = 4'b0010;
        set_req(1, 5'd9, DW'($urandom));
        glock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            check("lock_wload", 64'(wload), 64'(1));
            check("lock_wop", 64'(wop), 64'(5));
            check("lock_ready", 64'(ready), 64'(0));
            check("lock_busy", 64'(busy), 64'(1));
        end
        glock = 1'b0;
        cycle(g);
        valid = 4'b0000;
        cycle(g);
        check("lock_wr5_cnt", 64'(wr5_cnt - base5), 64'(1));
        check("lock_rf5", 64'(dut_rf[5]), 64'h0000_0000_DEAD_BEEF);

        // Wrap/sparse: pointer at 3 after a grant to 2.
        valid = 4'b0100;
        cycle(g);
        valid = 4'b1010;
        cycle(g);
        check("wrap_gnt3", 64'(g), 64'(3));
        valid = 4'b0010;
        cycle(g);
        check("wrap_gnt1", 64'(g), 64'(1));

        // Collision: two writers to register 7, the later grant wins.
        valid = 4'b1000;
        cycle(g);
        valid = 4'b0011;
        set_req(0, 5'd7, 32'h11);
        set_req(1, 5'd7, 32'h22);
        cycle(g);
        check("coll_gnt0", 64'(g), 64'(0));
        valid = 4'b0010;
        cycle(g);
        check("coll_gnt1", 64'(g), 64'(1));
        valid = 4'b0000;
        cycle(g);
        cycle(g);
        check("coll_rf7", 64'(dut_rf[7]), 64'h22);

        // Reset while a write is staged drops it.
        valid = 4'b0001;
        set_req(0, 5'd12, 32'hCAFE_0012);
        cycle(g);
        valid = 4'b0000;
        rstx = 1'b0;
        model_reset();
        #1;
        check("midrst_wload", 64'(wload), 64'(0));
        check("midrst_ready", 64'(ready), 64'(0));
        @(negedge clk);
        rstx = 1'b1;

        // Randomized traffic; requesters hold their request until accepted.
        last_g = -1;
        for (int c = 0; c < 3000; c++) begin
            glock = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!valid[i] || last_g == i) begin
                    valid[i] = 1'($urandom_range(0, 1));
                    set_req(i, AW'($urandom), DW'($urandom));
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                rstx = 1'b0;
                model_reset();
                #1;
                check("rnd_rst_wload", 64'(wload), 64'(0));
                @(negedge clk);
                rstx = 1'b1;
                last_g = -1;
            end else begin
                cycle(g);
                last_g = g;
            end
        end
        valid = '0;
        glock = 1'b0;
        cycle(g);
        cycle(g);
        for (int r = 0; r < 32; r++) check("rf_final", 64'(dut_rf[r]), 64'(m_rf[r]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
